// File: rtl/led_pkg.sv
// Shared types for the LED fader: channel state encoding and full-scale duty helper.
package led_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RISING  = 2'd1,
        ST_ON      = 2'd2,
        ST_FALLING = 2'd3
    } led_state_t;

    function automatic int led_dmax(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One fading LED channel: ramp FSM, duty register and registered PWM compare.
// LED_FADER_GAMMA_EN adds a registered square-law duty correction (+1 cycle duty->led).
module led_fader_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tgt,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led,
    output logic                o_ramping
);

    localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(led_dmax(PWM_BITS));

    led_state_t          r_state, w_dir, w_state_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [PWM_BITS-1:0] w_cmp_duty, w_cmp_eff;
    logic                w_inc, w_dec, r_led;

    // Direction is resolved before the step so a same-cycle tick uses the new direction.
    // Reversals landing on an endpoint settle straight into OFF/ON, never stepping past it.
    always_comb begin
        w_dir = r_state;
        case (r_state)
            ST_OFF:     if (i_tgt)  w_dir = ST_RISING;
            ST_RISING:  if (!i_tgt) w_dir = (r_duty == '0) ? ST_OFF : ST_FALLING;
            ST_ON:      if (!i_tgt) w_dir = ST_FALLING;
            ST_FALLING: if (i_tgt)  w_dir = (r_duty == DMAX) ? ST_ON : ST_RISING;
            default:    w_dir = ST_OFF;
        endcase
        w_inc       = i_tick && (w_dir == ST_RISING);
        w_dec       = i_tick && (w_dir == ST_FALLING);
        w_duty_nxt  = r_duty;
        w_state_nxt = w_dir;
        if (w_inc && (r_duty != DMAX)) w_duty_nxt = r_duty + 1'b1;
        if (w_dec && (r_duty != '0))   w_duty_nxt = r_duty - 1'b1;
        if ((w_dir == ST_RISING) && (w_duty_nxt == DMAX)) w_state_nxt = ST_ON;
        if ((w_dir == ST_FALLING) && (w_duty_nxt == '0))  w_state_nxt = ST_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [PWM_BITS-1:0]   r_duty_eff, r_duty_raw;
    logic [2*PWM_BITS-1:0] w_sq;

    assign w_sq = {{PWM_BITS{1'b0}}, r_duty} * {{PWM_BITS{1'b0}}, r_duty};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_eff <= '0;
            r_duty_raw <= '0;
        end else begin
            r_duty_eff <= PWM_BITS'(w_sq >> PWM_BITS);
            r_duty_raw <= r_duty;
        end
    end

    assign w_cmp_duty = r_duty_raw;
    assign w_cmp_eff  = r_duty_eff;
`else
    assign w_cmp_duty = r_duty;
    assign w_cmp_eff  = r_duty;
`endif

    // Endpoints override the compare so full scale is solid on with no one-slot dropout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= 1'b0;
        end else if (w_cmp_duty == DMAX) begin
            r_led <= 1'b1;
        end else if (w_cmp_duty == '0) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (i_pwm_cnt < w_cmp_eff);
        end
    end

    assign o_led     = r_led;
    assign o_ramping = (r_state == ST_RISING) || (r_state == ST_FALLING);

    a_no_inc_at_max: assert property (@(posedge clk) disable iff (rst) !(w_inc && (r_duty == DMAX)));
    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (rst) !(w_dec && (r_duty == '0)));

endmodule

// File: rtl/led_fader.sv
// PWM LED fader: per-LED duty ramps between off and full scale, 1-cycle input register.
// Optional LED_FADER_GAMMA_EN applies square-law duty correction inside each channel.
module led_fader
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_BITS  = 8,
    parameter int STEP_LOG2 = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    logic [NUM_LEDS-1:0]  r_tgt;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [STEP_LOG2-1:0] r_prescaler;
    logic                 r_busy;
    logic                 w_tick;
    logic [NUM_LEDS-1:0]  w_led, w_ramping;

    assign w_tick = &r_prescaler;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt       <= '0;
            r_pwm_cnt   <= '0;
            r_prescaler <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_tgt       <= led_in;
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            r_prescaler <= r_prescaler + 1'b1;
            r_busy      <= |w_ramping;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tgt     (r_tgt[g]),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g]),
            .o_ramping (w_ramping[g])
        );
    end

    assign led_out = w_led;
    assign busy    = r_busy;

endmodule
